// File: rtl/cpu_pkg.sv
// Shared CPU definitions: NZCV flag indices, ALU op encodings, condition codes
// and the per-stage control-word layouts carried by control_pipeline.
package cpu_pkg;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_ctl_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110
  } cond_e;

  typedef struct packed {
    logic       pcs;
    logic       regw;
    logic       memw;
    logic       memtoreg;
    logic       alusrc;
    logic [1:0] alu_control;
    logic [1:0] flagw;
    logic [3:0] cond;
  } de_ctrl_t;

  typedef struct packed {
    logic pcsrc;
    logic regw;
    logic memw;
    logic memtoreg;
  } em_ctrl_t;

  typedef struct packed {
    logic pcsrc;
    logic regw;
    logic memtoreg;
  } mw_ctrl_t;

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register with synchronous reset and synchronous clear;
// reset wins over clear, both load zero.
module pipe_reg #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else if (clear) begin
      data_q <= '0;
    end else begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/control_pipeline.sv
// Carries decode control through E/M/W, applies the condition verdict to
// state-changing writes, and holds the architectural NZCV flags.
module control_pipeline
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       PCSD,
  input  logic       RegWD,
  input  logic       MemWD,
  input  logic       MemtoRegD,
  input  logic       ALUSrcD,
  input  logic [1:0] ALUControlD,
  input  logic [1:0] FlagWD,
  input  logic [3:0] CondD,
  input  logic [3:0] ALUFlagsE,
  input  logic       CondExE,
  input  logic       FlushE,
  output logic       ALUSrcE,
  output logic [1:0] ALUControlE,
  output logic       MemtoRegE,
  output logic [3:0] CondE,
  output logic [3:0] FlagsE,
  output logic       PCSrcE,
  output logic       RegWriteM,
  output logic       MemWriteM,
  output logic       MemtoRegM,
  output logic       PCSrcM,
  output logic       RegWriteW,
  output logic       MemtoRegW,
  output logic       PCSrcW,
  output logic       PCWrPendingF
);

  de_ctrl_t de_d, de_q;
  em_ctrl_t em_d, em_q;
  mw_ctrl_t mw_d, mw_q;

  logic       RegWriteE;
  logic       MemWriteE;
  logic [1:0] FlagWriteE;
  logic [1:0] nz_q, cv_q;

  always_comb begin
    de_d             = '0;
    de_d.pcs         = PCSD;
    de_d.regw        = RegWD;
    de_d.memw        = MemWD;
    de_d.memtoreg    = MemtoRegD;
    de_d.alusrc      = ALUSrcD;
    de_d.alu_control = ALUControlD;
    de_d.flagw       = FlagWD;
    de_d.cond        = CondD;
  end

  pipe_reg #(.WIDTH($bits(de_ctrl_t))) u_de_reg (
    .clk   (clk),
    .reset (reset),
    .clear (FlushE),
    .d_i   (de_d),
    .q_o   (de_q)
  );

  // Only writes are gated by the condition; MemtoReg/ALUSrc pass through.
  assign PCSrcE     = de_q.pcs & CondExE;
  assign RegWriteE  = de_q.regw & CondExE;
  assign MemWriteE  = de_q.memw & CondExE;
  assign FlagWriteE = de_q.flagw & {2{CondExE}};

  assign ALUSrcE     = de_q.alusrc;
  assign ALUControlE = de_q.alu_control;
  assign MemtoRegE   = de_q.memtoreg;
  assign CondE       = de_q.cond;

  always_ff @(posedge clk) begin
    if (reset) begin
      nz_q <= '0;
      cv_q <= '0;
    end else begin
      if (FlagWriteE[1]) nz_q <= ALUFlagsE[FLAG_N:FLAG_Z];
      if (FlagWriteE[0]) cv_q <= ALUFlagsE[FLAG_C:FLAG_V];
    end
  end

  assign FlagsE = {nz_q, cv_q};

  always_comb begin
    em_d          = '0;
    em_d.pcsrc    = PCSrcE;
    em_d.regw     = RegWriteE;
    em_d.memw     = MemWriteE;
    em_d.memtoreg = MemtoRegE;
  end

  pipe_reg #(.WIDTH($bits(em_ctrl_t))) u_em_reg (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .d_i   (em_d),
    .q_o   (em_q)
  );

  assign PCSrcM    = em_q.pcsrc;
  assign RegWriteM = em_q.regw;
  assign MemWriteM = em_q.memw;
  assign MemtoRegM = em_q.memtoreg;

  always_comb begin
    mw_d          = '0;
    mw_d.pcsrc    = em_q.pcsrc;
    mw_d.regw     = em_q.regw;
    mw_d.memtoreg = em_q.memtoreg;
  end

  pipe_reg #(.WIDTH($bits(mw_ctrl_t))) u_mw_reg (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .d_i   (mw_d),
    .q_o   (mw_q)
  );

  assign PCSrcW    = mw_q.pcsrc;
  assign RegWriteW = mw_q.regw;
  assign MemtoRegW = mw_q.memtoreg;

  assign PCWrPendingF = PCSD | PCSrcE | PCSrcM;

endmodule

// File: tb/tb_control_pipeline.sv
// Randomised bench for control_pipeline: a stage-history model predicts every
// output each cycle, and directed scenarios pin the model with literal values.
module tb_control_pipeline;

  logic       clk;
  logic       reset;
  logic       PCSD, RegWD, MemWD, MemtoRegD, ALUSrcD;
  logic [1:0] ALUControlD, FlagWD;
  logic [3:0] CondD, ALUFlagsE;
  logic       CondExE, FlushE;
  logic       ALUSrcE, MemtoRegE, PCSrcE;
  logic [1:0] ALUControlE;
  logic [3:0] CondE, FlagsE;
  logic       RegWriteM, MemWriteM, MemtoRegM, PCSrcM;
  logic       RegWriteW, MemtoRegW, PCSrcW, PCWrPendingF;

  int n_cmp = 0;
  int n_bad = 0;

  control_pipeline dut (
    .clk          (clk),
    .reset        (reset),
    .PCSD         (PCSD),
    .RegWD        (RegWD),
    .MemWD        (MemWD),
    .MemtoRegD    (MemtoRegD),
    .ALUSrcD      (ALUSrcD),
    .ALUControlD  (ALUControlD),
    .FlagWD       (FlagWD),
    .CondD        (CondD),
    .ALUFlagsE    (ALUFlagsE),
    .CondExE      (CondExE),
    .FlushE       (FlushE),
    .ALUSrcE      (ALUSrcE),
    .ALUControlE  (ALUControlE),
    .MemtoRegE    (MemtoRegE),
    .CondE        (CondE),
    .FlagsE       (FlagsE),
    .PCSrcE       (PCSrcE),
    .RegWriteM    (RegWriteM),
    .MemWriteM    (MemWriteM),
    .MemtoRegM    (MemtoRegM),
    .PCSrcM       (PCSrcM),
    .RegWriteW    (RegWriteW),
    .MemtoRegW    (MemtoRegW),
    .PCSrcW       (PCSrcW),
    .PCWrPendingF (PCWrPendingF)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: what instruction occupies each stage, plus the architectural flags.
  typedef struct packed {
    bit       pcs, regw, memw, memtoreg, alusrc;
    bit [1:0] aluc, flagw;
    bit [3:0] cond;
  } instr_t;

  instr_t   in_e;
  bit [3:0] m_bits;   // {pcsrc, regw, memw, memtoreg} of instruction in M
  bit [2:0] w_bits;   // {pcsrc, regw, memtoreg} of instruction in W
  bit [3:0] flags;
  bit       model_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      in_e        = '0;
      m_bits      = '0;
      w_bits      = '0;
      flags       = '0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      w_bits = {m_bits[3], m_bits[2], m_bits[0]};
      m_bits = {in_e.pcs && CondExE, in_e.regw && CondExE,
                in_e.memw && CondExE, in_e.memtoreg};
      if (in_e.flagw[1] && CondExE) flags[3:2] = ALUFlagsE[3:2];
      if (in_e.flagw[0] && CondExE) flags[1:0] = ALUFlagsE[1:0];
      if (FlushE) in_e = '0;
      else in_e = '{pcs: PCSD, regw: RegWD, memw: MemWD, memtoreg: MemtoRegD,
                    alusrc: ALUSrcD, aluc: ALUControlD, flagw: FlagWD, cond: CondD};
    end
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      chk("ALUSrcE",      {3'b0, ALUSrcE},      {3'b0, in_e.alusrc});
      chk("ALUControlE",  {2'b0, ALUControlE},  {2'b0, in_e.aluc});
      chk("MemtoRegE",    {3'b0, MemtoRegE},    {3'b0, in_e.memtoreg});
      chk("CondE",        CondE,                in_e.cond);
      chk("FlagsE",       FlagsE,               flags);
      chk("PCSrcE",       {3'b0, PCSrcE},       {3'b0, in_e.pcs && CondExE});
      chk("PCSrcM",       {3'b0, PCSrcM},       {3'b0, m_bits[3]});
      chk("RegWriteM",    {3'b0, RegWriteM},    {3'b0, m_bits[2]});
      chk("MemWriteM",    {3'b0, MemWriteM},    {3'b0, m_bits[1]});
      chk("MemtoRegM",    {3'b0, MemtoRegM},    {3'b0, m_bits[0]});
      chk("PCSrcW",       {3'b0, PCSrcW},       {3'b0, w_bits[2]});
      chk("RegWriteW",    {3'b0, RegWriteW},    {3'b0, w_bits[1]});
      chk("MemtoRegW",    {3'b0, MemtoRegW},    {3'b0, w_bits[0]});
      chk("PCWrPendingF", {3'b0, PCWrPendingF},
          {3'b0, PCSD || (in_e.pcs && CondExE) || m_bits[3]});
    end
  end

  task automatic d_zero();
    PCSD = 0; RegWD = 0; MemWD = 0; MemtoRegD = 0; ALUSrcD = 0;
    ALUControlD = 0; FlagWD = 0; CondD = 0;
  endtask

  task automatic d_rand();
    PCSD        = 1'($urandom);
    RegWD       = 1'($urandom);
    MemWD       = 1'($urandom);
    MemtoRegD   = 1'($urandom);
    ALUSrcD     = 1'($urandom);
    ALUControlD = 2'($urandom);
    FlagWD      = 2'($urandom);
    CondD       = 4'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1; FlushE = 0; CondExE = 1; ALUFlagsE = 4'hF;
    d_rand();
    @(negedge clk);
    chk("lit_reset_FlagsE",    FlagsE, 4'b0000);
    chk("lit_reset_RegWriteM", {3'b0, RegWriteM}, 4'd0);
    chk("lit_reset_RegWriteW", {3'b0, RegWriteW}, 4'd0);
    tick();
    d_rand();
    tick();
    reset = 0; CondExE = 0; ALUFlagsE = 0;
    d_zero();

    // Propagation: RegWD/MemtoRegD with CondD=AL
    RegWD = 1; MemtoRegD = 1; CondD = 4'b1110;
    tick();
    d_zero(); CondExE = 1;
    tick();
    CondExE = 0;
    @(negedge clk);
    chk("lit_prop_RegWriteM", {3'b0, RegWriteM}, 4'd1);
    tick();
    @(negedge clk);
    chk("lit_prop_RegWriteW", {3'b0, RegWriteW}, 4'd1);
    chk("lit_prop_MemtoRegW", {3'b0, MemtoRegW}, 4'd1);

    // Condition fail: nothing written, flags untouched
    MemWD = 1; PCSD = 1; FlagWD = 2'b11;
    tick();
    d_zero(); CondExE = 0; ALUFlagsE = 4'b1111;
    tick();
    ALUFlagsE = 0;
    @(negedge clk);
    chk("lit_cfail_MemWriteM", {3'b0, MemWriteM}, 4'd0);
    chk("lit_cfail_PCSrcM",    {3'b0, PCSrcM},    4'd0);
    chk("lit_cfail_FlagsE",    FlagsE,            4'b0000);

    // Partial flag write: only N,Z
    FlagWD = 2'b10;
    tick();
    d_zero(); CondExE = 1; ALUFlagsE = 4'b1111;
    tick();
    CondExE = 0; ALUFlagsE = 0;
    @(negedge clk);
    chk("lit_partial_FlagsE", FlagsE, 4'b1100);

    // Flush: instruction in E still completes, incoming one becomes a bubble
    RegWD = 1; FlagWD = 2'b01;
    tick();
    d_zero(); RegWD = 1; FlushE = 1; CondExE = 1; ALUFlagsE = 4'b0011;
    tick();
    d_zero(); FlushE = 0; CondExE = 1; ALUFlagsE = 0;
    @(negedge clk);
    chk("lit_flush_RegWriteM_old", {3'b0, RegWriteM}, 4'd1);
    chk("lit_flush_FlagsE",        FlagsE,            4'b1111);
    chk("lit_flush_E_empty",       {ALUSrcE, MemtoRegE, ALUControlE}, 4'd0);
    tick();
    CondExE = 0;
    @(negedge clk);
    chk("lit_flush_RegWriteM_bubble", {3'b0, RegWriteM}, 4'd0);

    // PC write pending across D, E, M; clear in W
    PCSD = 1;
    @(negedge clk);
    chk("lit_pcpend_D", {3'b0, PCWrPendingF}, 4'd1);
    tick();
    d_zero(); CondExE = 1;
    @(negedge clk);
    chk("lit_pcpend_E", {3'b0, PCWrPendingF}, 4'd1);
    tick();
    CondExE = 0;
    @(negedge clk);
    chk("lit_pcpend_M", {3'b0, PCWrPendingF}, 4'd1);
    tick();
    @(negedge clk);
    chk("lit_pcpend_W",        {3'b0, PCWrPendingF}, 4'd0);
    chk("lit_pcpend_PCSrcW",   {3'b0, PCSrcW},       4'd1);

    // Randomised traffic against the model
    for (int unsigned i = 0; i < 3000; i++) begin
      tick();
      d_rand();
      ALUFlagsE = 4'($urandom);
      CondExE   = ($urandom_range(0, 3) != 0);
      FlushE    = ($urandom_range(0, 5) == 0);
      reset     = ($urandom_range(0, 49) == 0);
    end
    tick();
    reset = 0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
